// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the arbiter state encoding and the default starvation limit.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_PEND = 2'd1,
    D_PEND  = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_arbiter_addr_check.sv
// Byte address to RAM word index, flagging misaligned
// or out-of-range addresses.
module arb_addr_check #(
  parameter int ADDR_W = 10
) (
  input  logic [31:0]       addr,
  output logic [ADDR_W-1:0] idx,
  output logic              err
);

  assign idx = addr[ADDR_W+1:2];
  assign err = (addr[1:0] != 2'b00) ||
               (addr[31:ADDR_W+2] != '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port RAM with
// one-cycle read latency and starvation relief for fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_re,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              if_stall,
  output logic              d_stall,
  output logic              addr_err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 :
                      $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_t        state, state_nx;
  logic [SW-1:0]     starve_cnt, starve_nx;
  logic              gnt_if, gnt_d;
  logic              pend_we, pend_err;
  logic [ADDR_W-1:0] if_idx, d_idx;
  logic              if_err, d_err;

  arb_addr_check #(.ADDR_W(ADDR_W)) u_if_chk (
    .addr (if_addr),
    .idx  (if_idx),
    .err  (if_err)
  );

  arb_addr_check #(.ADDR_W(ADDR_W)) u_d_chk (
    .addr (d_addr),
    .idx  (d_idx),
    .err  (d_err)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      pend_we    <= 1'b0;
      pend_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      if (gnt_d) begin
        pend_we  <= d_we;
        pend_err <= d_err;
      end else if (gnt_if) begin
        pend_we  <= 1'b0;
        pend_err <= if_err;
      end
    end
  end

  always_comb begin
    gnt_if    = 1'b0;
    gnt_d     = 1'b0;
    state_nx  = IDLE;
    starve_nx = starve_cnt;
    unique case (state)
      IDLE: begin
        if (d_req && !(if_req && starve_cnt == SMAX))
          gnt_d = 1'b1;
        else if (if_req)
          gnt_if = 1'b1;
      end
      IF_PEND: gnt_d  = d_req;
      D_PEND:  gnt_if = if_req;
      default: ;
    endcase
    if (gnt_d)
      state_nx = D_PEND;
    else if (gnt_if)
      state_nx = IF_PEND;
    // Only IDLE conflicts lost by fetch count toward starvation
    if (gnt_if)
      starve_nx = '0;
    else if (gnt_d && state == IDLE && if_req &&
             starve_cnt != SMAX)
      starve_nx = starve_cnt + SW'(1);
  end

  always_comb begin
    if_ready  = 1'b0;
    if_rdata  = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    addr_err  = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_wdata = '0;
    if (reset) begin
      if (gnt_d) begin
        ram_addr  = d_idx;
        ram_we    = d_we;
        ram_re    = !d_we;
        ram_wdata = d_wdata;
      end else if (gnt_if) begin
        ram_addr  = if_idx;
        ram_re    = 1'b1;
      end
      if (state == IF_PEND) begin
        if_ready = 1'b1;
        if_rdata = ram_rdata;
        addr_err = pend_err;
      end
      if (state == D_PEND) begin
        d_ready  = 1'b1;
        d_rdata  = pend_we ? '0 : ram_rdata;
        addr_err = pend_err;
      end
    end
  end

  assign if_stall = if_req && !if_ready;
  assign d_stall  = d_req && !d_ready;

endmodule
